// File: rtl/instr_encoder_loader.sv
// Packs instruction fields from a valid/ready stream into 16-bit CPU words and writes
// them sequentially into instruction RAM. Optional immediate range check: ENC_RANGE_CHECK_EN.
module instr_encoder_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_opcode,
  input  logic [2:0]        in_rd,
  input  logic [2:0]        in_rs,
  input  logic [2:0]        in_rt,
  input  logic [10:0]       in_imm,
  input  logic [1:0]        in_func,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam int CNT_W = ADDR_W + 1;

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_LHI  = 5'b00001;
  localparam logic [4:0] OP_LLI  = 5'b00010;
  localparam logic [4:0] OP_LDR  = 5'b00011;
  localparam logic [4:0] OP_STR  = 5'b00101;
  localparam logic [4:0] OP_CMP  = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b00111;
  localparam logic [4:0] OP_SUBI = 5'b01000;
  localparam logic [4:0] OP_MOV  = 5'b01011;
  localparam logic [4:0] OP_JMP  = 5'b10000;
  localparam logic [4:0] OP_JALL = 5'b10001;
  localparam logic [4:0] OP_JALR = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_BCC  = 5'b11000;
  localparam logic [4:0] OP_BAL  = 5'b11001;
  localparam logic [4:0] OP_SYS  = 5'b11100;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FLUSH = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [CNT_W-1:0]   acc_q;
  logic [CNT_W-1:0]   word_count_q;
  logic               mem_we_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [15:0]        mem_wdata_q;

  logic [15:0]        enc_word;
  logic               op_ok;
  logic               beat_legal;
  logic               accept;
  logic               ovf;
  logic               wr_ok;
  logic               bad_beat;
  logic               sess_start;

  // Field packing; every opcode occupies [15:11].
  always_comb begin
    enc_word = '0;
    op_ok    = 1'b1;
    case (in_opcode)
      OP_LHI, OP_LLI, OP_JALL:         enc_word = {in_opcode, in_rd, in_imm[7:0]};
      OP_LDR, OP_STR, OP_ADDI, OP_SUBI: enc_word = {in_opcode, in_rd, in_rs, in_imm[4:0]};
      OP_ALU, OP_CMP:                  enc_word = {in_opcode, in_rd, in_rs, in_rt, in_func};
      OP_MOV, OP_JALR:                 enc_word = {in_opcode, in_rd, in_rs, 5'b0};
      OP_JR:                           enc_word = {in_opcode, 3'b0, in_rs, 5'b0};
      OP_BCC:                          enc_word = {in_opcode, 1'b0, in_func, in_imm[7:0]};
      OP_BAL:                          enc_word = {in_opcode, 3'b0, in_imm[7:0]};
      OP_JMP:                          enc_word = {in_opcode, in_imm};
      OP_SYS: begin
        // func==00 selects OutR, anything else is HLT
        if (in_func == 2'b00) enc_word = {in_opcode, 3'b0, in_rs, 5'b0};
        else                  enc_word = {in_opcode, 9'b0, 2'b01};
      end
      default:                         op_ok = 1'b0;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  logic imm_ok;

  always_comb begin
    imm_ok = 1'b1;
    case (in_opcode)
      OP_LHI, OP_LLI:                   imm_ok = (in_imm[10:8] == 3'b000);
      OP_LDR, OP_STR, OP_ADDI, OP_SUBI: imm_ok = (in_imm[10:5] == 6'b000000);
      OP_BCC, OP_BAL, OP_JALL:          imm_ok = (in_imm[10:7] == 4'b0000) ||
                                                 (in_imm[10:7] == 4'b1111);
      default:                          imm_ok = 1'b1;
    endcase
  end

  assign beat_legal = op_ok & imm_ok;
`else
  assign beat_legal = op_ok;
`endif

  // acc_q counts accepted writes, so overflow sees the word still in flight
  assign accept     = in_valid & in_ready;
  assign ovf        = (acc_q >= CNT_W'(DEPTH));
  assign wr_ok      = accept & beat_legal & ~ovf;
  assign bad_beat   = accept & (~beat_legal | ovf);
  assign sess_start = start & ((state_q == S_IDLE) | (state_q == S_DONE) | (state_q == S_ERR));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD: begin
        if (bad_beat)             state_d = S_ERR;
        else if (wr_ok & in_last) state_d = S_FLUSH;
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE:  if (start) state_d = S_LOAD;
      S_ERR:   if (start) state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == S_LOAD);
    busy     = (state_q == S_LOAD) | (state_q == S_FLUSH);
    done     = (state_q == S_DONE);
    err      = (state_q == S_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= ADDR_W'(BASE);
      acc_q        <= '0;
      word_count_q <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      mem_we_q <= wr_ok;
      if (wr_ok) begin
        mem_addr_q  <= addr_q;
        mem_wdata_q <= enc_word;
      end
      if (sess_start) begin
        addr_q       <= ADDR_W'(BASE);
        acc_q        <= '0;
        word_count_q <= '0;
      end else begin
        if (wr_ok) begin
          addr_q <= addr_q + ADDR_W'(1);
          acc_q  <= acc_q + CNT_W'(1);
        end
        if (mem_we_q) word_count_q <= word_count_q + CNT_W'(1);
      end
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: driver predicts writes from an arithmetic
// encoding model, a negedge monitor pops and compares every RAM write.
module tb_instr_encoder_loader;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 12;
  localparam int BASE   = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, in_valid, in_ready, in_last;
  logic [4:0]        in_opcode;
  logic [2:0]        in_rd, in_rs, in_rt;
  logic [10:0]       in_imm;
  logic [1:0]        in_func;
  logic              mem_we, busy, done, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [ADDR_W:0]   word_count;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
    .in_func(in_func), .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int addr; int data; int cyc; } exp_t;
  exp_t sbq[$];

  int  exp_acc;
  bit  sess_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Encoding model: place value arithmetic on field positions.
  function automatic int model_enc(int op, int rd, int rs, int rt, int imm, int func);
    int w;
    w = op * 2048;
    case (op)
      1, 2, 17:    w += rd * 256 + imm % 256;
      3, 5, 7, 8:  w += rd * 256 + rs * 32 + imm % 32;
      0, 6:        w += rd * 256 + rs * 32 + rt * 4 + func;
      11, 18:      w += rd * 256 + rs * 32;
      19:          w += rs * 32;
      24:          w += func * 256 + imm % 256;
      25:          w += imm % 256;
      16:          w += imm;
      28:          w += (func == 0) ? rs * 32 : 1;
      default:     w += 0;
    endcase
    return w;
  endfunction

  function automatic bit legal_op(int op);
    case (op)
      0, 1, 2, 3, 5, 6, 7, 8, 11, 16, 17, 18, 19, 24, 25, 28: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit imm_in_range(int op, int imm);
`ifdef ENC_RANGE_CHECK_EN
    case (op)
      1, 2:        return imm < 256;
      3, 5, 7, 8:  return imm < 32;
      17, 24, 25:  return (imm < 128) || (imm >= 2048 - 128);
      default:     return 1'b1;
    endcase
`else
    return (op >= 0) || (imm >= 0);
`endif
  endfunction

  always @(negedge clk) begin
    if (rst_n && mem_we === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write", mem_addr, mem_wdata);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("wr_addr", 32'(mem_addr), e.addr);
        check("wr_data", 32'(mem_wdata), e.data);
        check("wr_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic idle_inputs();
    start = 0; in_valid = 0; in_last = 0; in_opcode = 0; in_rd = 0; in_rs = 0;
    in_rt = 0; in_imm = 0; in_func = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"}, mem_we, 0);
    check({tag, "_addr"}, 32'(mem_addr), 0);
    check({tag, "_wdata"}, 32'(mem_wdata), 0);
    check({tag, "_flags"}, {busy, done, err, in_ready}, 0);
    check({tag, "_wc"}, 32'(word_count), 0);
  endtask

  task automatic start_session();
    @(negedge clk);
    start = 1; in_valid = 0;
    @(negedge clk);
    start = 0;
    exp_acc = 0; sess_bad = 0;
    check("start_ready", {in_ready, busy, done, err}, 4'b1100);
    check("start_wc", 32'(word_count), 0);
  endtask

  task automatic beat(input int op, rd, rs, rt, imm, func, input bit last, output bit ended);
    bit legal;
    int gap;
    gap = $urandom_range(0, 2);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      in_valid = 0;
    end
    @(negedge clk);
    in_opcode = 5'(op); in_rd = 3'(rd); in_rs = 3'(rs); in_rt = 3'(rt);
    in_imm = 11'(imm); in_func = 2'(func); in_last = last; in_valid = 1;
    check("beat_ready", in_ready, 1);
    legal = legal_op(op) && imm_in_range(op, imm) && (exp_acc < DEPTH);
    if (legal) begin
      sbq.push_back('{addr: (BASE + exp_acc) % (1 << ADDR_W),
                      data: model_enc(op, rd, rs, rt, imm, func), cyc: cyc + 1});
      exp_acc++;
    end else sess_bad = 1;
    ended = !legal || last;
    @(posedge clk);
    #1 in_valid = 0; in_last = 0;
  endtask

  task automatic finish_session(input string tag);
    int n;
    n = 0;
    while (!(done === 1'b1 || err === 1'b1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done/err expected one within 20 cycles", tag);
    end
    @(negedge clk);
    @(negedge clk);
    check({tag, "_done_err"}, {done, err}, sess_bad ? 2'b01 : 2'b10);
    check({tag, "_wc"}, 32'(word_count), exp_acc);
    check({tag, "_idle"}, {busy, in_ready}, 0);
    check({tag, "_sbq_empty"}, sbq.size(), 0);
  endtask

  task automatic junk_beats(input string tag);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_opcode = 5'b00010; in_rd = 3'($urandom); in_imm = 11'($urandom); in_valid = 1;
      check({tag, "_ready_low"}, in_ready, 0);
    end
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic rand_session(input int nbeats, input string tag);
    bit ended;
    int op;
    start_session();
    ended = 0;
    for (int i = 0; i < nbeats && !ended; i++) begin
      int ops[16] = '{0, 1, 2, 3, 5, 6, 7, 8, 11, 16, 17, 18, 19, 24, 25, 28};
      op = ops[$urandom_range(0, 15)];
      if ($urandom_range(0, 19) == 0) op = $urandom_range(0, 31);
      beat(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
           ($urandom_range(0, 1) == 1) ? $urandom_range(0, 31) : $urandom_range(0, 2047),
           $urandom_range(0, 3), i == nbeats - 1, ended);
    end
    finish_session(tag);
  endtask

  bit ended;

  initial begin
    idle_inputs();
    rst_n = 0;
    #23;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1;
    junk_beats("idle_valid");
    check("idle_wc", 32'(word_count), 0);

    // LLI then HLT: 0x115A, 0xE001
    start_session();
    beat(2, 1, 0, 0, 'h5A, 0, 0, ended);
    beat(28, 0, 0, 0, 0, 1, 1, ended);
    finish_session("lli_hlt");
    junk_beats("done_valid");

    // ADD, Bcc -2, with a start pulse mid-session that must be ignored
    start_session();
    beat(0, 2, 3, 4, 0, 0, 0, ended);
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    check("start_ignored_busy", busy, 1);
    beat(24, 0, 0, 0, 'h7FE, 1, 0, ended);
    beat(28, 0, 5, 0, 0, 0, 1, ended);
    finish_session("add_bcc");

    // illegal opcode mid-session
    start_session();
    beat(7, 1, 2, 0, 3, 0, 0, ended);
    beat(15, 1, 1, 1, 1, 1, 0, ended);
    finish_session("illegal");
    junk_beats("err_valid");

    // exactly DEPTH words with last on the final one
    start_session();
    for (int i = 0; i < DEPTH; i++) beat(16, 0, 0, 0, $urandom_range(0, 2047), 0, i == DEPTH - 1, ended);
    finish_session("full_depth");

    // one beat beyond DEPTH without last
    start_session();
    for (int i = 0; i <= DEPTH; i++) beat(19, 0, i % 8, 0, 0, 0, 0, ended);
    finish_session("overflow");

    // ADDI imm=0x20: truncated by default, rejected with range check
    start_session();
    beat(7, 2, 3, 0, 'h20, 0, 1, ended);
    finish_session("addi_range");

    for (int s = 0; s < 8; s++) rand_session($urandom_range(1, DEPTH), $sformatf("rand%0d", s));

    // async reset right after a beat is accepted drops the pending write
    start_session();
    @(negedge clk);
    in_opcode = 5'd2; in_rd = 3'd3; in_imm = 11'h33; in_valid = 1;
    @(posedge clk);
    #1 rst_n = 0;
    in_valid = 0;
    #1 check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check_all_zero("post_reset");

    rand_session(5, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish before 400us");
    $fatal(1, "timeout");
  end

endmodule
